// File: rtl/prio_enc_drain_pkg.sv
// Shared types and helpers for the priority-encode-and-drain block.
// Holds the FSM state type, the default widths and a generic popcount.
package prio_enc_pkg;

  localparam int N_IN_DFLT   = 8;
  localparam int CODE_W_DFLT = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc_drain_if.sv
// Request-in / code-out handshake bundle for prio_enc_drain.
// master is the request/consumer side, slave is the encoder itself.
interface prio_enc_drain_if
  import prio_enc_pkg::*;
#(
  parameter int N_IN   = N_IN_DFLT,
  parameter int CODE_W = CODE_W_DFLT
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_last;
  logic [CODE_W:0]   pend_cnt;
  logic              zero_drop;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_last, pend_cnt, zero_drop
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_last, pend_cnt, zero_drop
  );
endinterface

// File: rtl/prio_enc_drain_lsb_onehot_enc.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set
// bit and a flag that any bit is set.
module lsb_onehot_enc
  import prio_enc_pkg::*;
#(
  parameter int N_IN   = N_IN_DFLT,
  parameter int CODE_W = CODE_W_DFLT
) (
  input  logic [N_IN-1:0]   vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    code = '0;
    any  = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec[i]) begin
        code = CODE_W'(i);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_drain.sv
// Drains an accepted request vector as one binary code per handshake, lowest first.
// Outputs decode from the pend register only; one idle bubble between vectors.
module prio_enc_drain
  import prio_enc_pkg::*;
#(
  parameter int N_IN   = N_IN_DFLT,
  parameter int CODE_W = CODE_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  prio_enc_drain_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_DRAIN = DRAIN;

  if (CODE_W != $clog2(N_IN)) begin : g_bad_width
    $error("prio_enc_drain: CODE_W must equal clog2(N_IN)");
  end

  logic [0:0]        state;
  logic [N_IN-1:0]   pend;
  logic              zero_drop_q;
  logic [CODE_W-1:0] enc_code;
  logic              enc_any;
  logic [CODE_W:0]   cnt;
  logic              draining;
  logic              last;

  lsb_onehot_enc #(
    .N_IN   (N_IN),
    .CODE_W (CODE_W)
  ) u_enc (
    .vec  (pend),
    .code (enc_code),
    .any  (enc_any)
  );

  assign cnt      = (CODE_W + 1)'(popcount(32'(pend)));
  assign draining = (state == S_DRAIN);
  assign last     = draining && (cnt == (CODE_W + 1)'(1));

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = draining && enc_any;
  assign bus.out_code  = draining ? enc_code : '0;
  assign bus.out_last  = last;
  assign bus.pend_cnt  = cnt;
  assign bus.zero_drop = zero_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pend        <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      zero_drop_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_vec != '0) begin
              pend  <= bus.in_vec;
              state <= S_DRAIN;
            end else begin
              zero_drop_q <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            // Clearing the lowest set bit matches the code just presented.
            pend <= pend & (pend - 1'b1);
            if (last) begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_enc_drain.sv
// Scoreboard bench for prio_enc_drain: directed scenarios plus randomized vectors
// with random backpressure, checked against a per-bit reference expansion.
module tb_prio_enc_drain;

  typedef struct {
    int code;
    int last;
    int cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pops;
  int   zd_seen;
  int   zd_exp;
  bit   rand_bp;
  exp_t expq[$];

  prio_enc_drain_if bus ();

  prio_enc_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every set bit yields one code, lowest first; the pending count
  // for bit i is the number of set bits at index i or above.
  task automatic push_expected(input logic [7:0] v);
    exp_t e;
    int   n;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        n = 0;
        for (int j = i; j < 8; j++) n += int'(v[j]);
        e.code = i;
        e.cnt  = n;
        e.last = (n == 1) ? 1 : 0;
        expq.push_back(e);
      end
    end
    if (v == 8'h00) zd_exp++;
  endtask

  task automatic send(input logic [7:0] v);
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check("wait_in_ready", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    push_expected(v);
    tick();
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'h00;
  endtask

  task automatic wait_drained(input string name);
    int k;
    k = 0;
    while ((expq.size() != 0 || bus.out_valid !== 1'b0) && k < 1000) begin
      tick();
      k++;
    end
    check(name, expq.size(), 0);
  endtask

  // Monitor: compare every presented code against the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (bus.zero_drop === 1'b1) zd_seen++;
    if (bus.out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_out", {29'd0, bus.out_code}, 99);
      end else begin
        check("out_code", {29'd0, bus.out_code}, expq[0].code);
        check("pend_cnt", {28'd0, bus.pend_cnt}, expq[0].cnt);
        check("out_last", {31'd0, bus.out_last}, expq[0].last);
        if (bus.out_ready === 1'b1) begin
          void'(expq.pop_front());
          pops++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    logic [7:0] v;
    checks = 0; failures = 0; pops = 0; zd_seen = 0; zd_exp = 0; rand_bp = 1'b0;
    bus.in_valid = 1'b0; bus.in_vec = 8'h00; bus.out_ready = 1'b1;

    // 1. reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_code", {29'd0, bus.out_code}, 0);
    check("rst_out_last", {31'd0, bus.out_last}, 0);
    check("rst_pend_cnt", {28'd0, bus.pend_cnt}, 0);
    check("rst_zero_drop", {31'd0, bus.zero_drop}, 0);

    // 2. 1001_0100 at full rate
    base = pops;
    send(8'b1001_0100);
    check("t2_first_valid", {31'd0, bus.out_valid}, 1);
    check("t2_in_ready_busy", {31'd0, bus.in_ready}, 0);
    tick(); tick(); tick();
    check("t2_pops", pops - base, 3);
    check("t2_in_ready_after", {31'd0, bus.in_ready}, 1);
    check("t2_valid_after", {31'd0, bus.out_valid}, 0);

    // 3. backpressure hold
    bus.out_ready = 1'b0;
    base = pops;
    send(8'h05);
    for (int i = 0; i < 5; i++) tick();
    check("t3_held_no_pop", pops - base, 0);
    check("t3_held_code", {29'd0, bus.out_code}, 0);
    check("t3_held_cnt", {28'd0, bus.pend_cnt}, 2);
    bus.out_ready = 1'b1;
    wait_drained("t3_drained");
    check("t3_pops", pops - base, 2);

    // 4. zero vector
    send(8'h00);
    check("t4_zero_drop", {31'd0, bus.zero_drop}, 1);
    check("t4_in_ready", {31'd0, bus.in_ready}, 1);
    check("t4_out_valid", {31'd0, bus.out_valid}, 0);
    tick();
    check("t4_zero_drop_pulse", {31'd0, bus.zero_drop}, 0);

    // 5. reset mid-drain of FF after the 3rd pop
    base = pops;
    send(8'hFF);
    k = 0;
    while (pops - base < 3 && k < 50) begin
      tick();
      k++;
    end
    check("t5_three_pops", pops - base, 3);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expq.delete();
    check("t5_valid_after_rst", {31'd0, bus.out_valid}, 0);
    check("t5_cnt_after_rst", {28'd0, bus.pend_cnt}, 0);
    check("t5_in_ready_after_rst", {31'd0, bus.in_ready}, 1);
    bus.out_ready = 1'b1;
    send(8'h80);
    check("t5_code7", {29'd0, bus.out_code}, 7);
    check("t5_last7", {31'd0, bus.out_last}, 1);
    wait_drained("t5_drained");

    // 6. input ignored while draining
    base = pops;
    send(8'h03);
    bus.in_valid = 1'b1;
    bus.in_vec   = 8'h80;
    check("t6_busy0", {31'd0, bus.in_ready}, 0);
    tick();
    check("t6_busy1", {31'd0, bus.in_ready}, 0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'h00;
    check("t6_ready_after", {31'd0, bus.in_ready}, 1);
    wait_drained("t6_drained");
    check("t6_pops", pops - base, 2);

    // random vectors with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      if ($urandom_range(0, 9) == 0) v = 8'hFF;
      send(v);
    end
    wait_drained("rand_drained");
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    check("zero_drop_count", zd_seen, zd_exp);
    check("final_idle", {31'd0, bus.in_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
